// File: rtl/cpu_fetch_pkg.sv
// Shared definitions for the instruction fetch path: FSM state encoding,
// instruction width in bytes and the default per-byte memory wait limit.
package cpu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    localparam int BYTES_PER_INS      = 4;
    localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/ins_byte_packer.sv
// Shift-in shadow register that assembles an instruction one byte at a time,
// first byte ending up in [31:24]. word_next exposes the value after the shift.
module ins_byte_packer (
    input  logic        clk_sys,
    input  logic        rst_b,
    input  logic        clr,
    input  logic        shift_en,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic [31:0] word_next
);

    assign word_next = {word[23:0], din};

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            word <= '0;
        end else if (clr) begin
            word <= '0;
        end else if (shift_en) begin
            word <= word_next;
        end
    end

endmodule

// File: rtl/ins_fetch_unit.sv
// Instruction fetch sequencer: four byte reads packed big-endian into Ins_Data.
// Optional per-byte wait timeout compiled in with FETCH_TIMEOUT_EN.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   ST_IDLE | waiting for fetch_req; misaligned PC pulses fault
//   ST_RD   | reading byte base+byte_cnt, capturing on mem_ready
//   ST_DONE | Ins_Data valid, IRWre/fetch_done pulse, back to idle
module ins_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        fetch_req,
    input  logic [31:0] PC_in,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_ready,
    output logic [31:0] Ins_Data,
    output logic        IRWre,
    output logic        fetch_done,
    output logic        fault,
    output logic        busy
);

    fetch_state_e state;
    logic [31:0]  base;
    logic [1:0]   byte_cnt;
    logic         accept;
    logic         misaligned;
    logic         capture;
    logic         last_byte;
    logic         timeout_hit;
    logic [31:0]  shadow_word;
    logic [31:0]  shadow_next;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    assign misaligned = (PC_in[1:0] != 2'b00);
    assign accept     = (state == ST_IDLE) && fetch_req && !misaligned;
    assign capture    = (state == ST_RD) && mem_ready;
    assign last_byte  = (byte_cnt == 2'(BYTES_PER_INS - 1));

    assign mem_rd     = (state == ST_RD);
    assign mem_addr   = mem_rd ? (base + {30'd0, byte_cnt}) : '0;
    assign IRWre      = (state == ST_DONE);
    assign fetch_done = (state == ST_DONE);
    assign busy       = (state != ST_IDLE);

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;

    // Down-counter reloads on every captured byte; terminal count is the limit.
    assign timeout_hit = (state == ST_RD) && !mem_ready && (wait_cnt == '0);

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state != ST_RD) || mem_ready) begin
            wait_cnt <= WAIT_LOAD;
        end else if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    ins_byte_packer u_packer (
        .clk_sys   (CLK),
        .rst_b     (Reset),
        .clr       (accept),
        .shift_en  (capture),
        .din       (mem_data),
        .word      (shadow_word),
        .word_next (shadow_next)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= ST_IDLE;
            base     <= '0;
            byte_cnt <= '0;
            Ins_Data <= '0;
            fault    <= 1'b0;
        end else begin
            fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fetch_req && misaligned) begin
                        fault <= 1'b1;
                    end else if (accept) begin
                        base     <= PC_in;
                        byte_cnt <= '0;
                        state    <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (capture) begin
                        byte_cnt <= byte_cnt + 1'b1;
                        if (last_byte) begin
                            Ins_Data <= shadow_next;
                            state    <= ST_DONE;
                        end
                    end else if (timeout_hit) begin
                        fault    <= 1'b1;
                        byte_cnt <= '0;
                        state    <= ST_IDLE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ins_fetch_unit.md
# ins_fetch_unit

Instruction fetch sequencer for the multi-cycle CPU. It is the writer side of the instruction register. On a fetch request from the control unit it reads one 32-bit instruction from the byte-wide instruction memory at the current PC. It performs four byte reads, packs them big-endian, then presents the word on `Ins_Data` with a one-cycle `IRWre` pulse. The instruction register captures the word on the falling edge of that cycle.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 16: maximum wait for `mem_ready` per byte. Used only when the timeout feature is compiled in.

Ports:
- `CLK`, in, 1: single clock; all state updates on the rising edge.
- `Reset`, in, 1: asynchronous, active-low reset.
- `fetch_req`, in, 1: start a fetch; sampled only in IDLE.
- `PC_in`, in, 32: byte address of the instruction; latched on accept.
- `mem_addr`, out, 32: byte address to instruction memory.
- `mem_rd`, out, 1: read strobe.
- `mem_data`, in, 8: read byte; valid when `mem_ready`=1.
- `mem_ready`, in, 1: byte valid; ignored while `mem_rd`=0.
- `Ins_Data`, out, 32: assembled instruction; holds its value until the next successful fetch.
- `IRWre`, out, 1: one-cycle write strobe to the instruction register.
- `fetch_done`, out, 1: one-cycle completion pulse, coincident with `IRWre`.
- `fault`, out, 1: one-cycle abort pulse.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
States:
- **IDLE**: `busy`=0. If `fetch_req`=1:
  - `PC_in[1:0]`≠0: pulse `fault` next cycle, stay in IDLE, no memory access.
  - Otherwise latch `base=PC_in`, set `byte_cnt=0`, go to RD.
- **RD**:
  - Drive `mem_rd`=1 and `mem_addr=base+byte_cnt`, where `byte_cnt` is 2 bits.
  - On each edge with `mem_ready`=1, capture the byte: byte 0 goes to `[31:24]` and byte 3 goes to `[7:0]`.
  - After capturing byte 3, go to DONE; otherwise increment `byte_cnt`.
- **DONE**: `IRWre`=1, `fetch_done`=1, `Ins_Data` = assembled word. Return to IDLE next edge.

Rules:
- Bytes are packed into a shadow register. `Ins_Data` updates only on entering DONE, so partial words are never visible.
- `fetch_req` while `busy`=1 is ignored; it is not queued.
- A held `fetch_req` is re-accepted on the first IDLE cycle.
- `mem_addr` is 0 whenever `mem_rd`=0.
- Address arithmetic is 32-bit modulo. With an aligned base there is no carry out of bits [1:0].
- Reset, asserted at any time, forces:
  - state IDLE;
  - `Ins_Data`=0, `byte_cnt`=0;
  - all outputs 0.
  - No `IRWre` is emitted for an interrupted fetch.

## Timing
- Reset values: `mem_addr`=0, `mem_rd`=0, `Ins_Data`=0, `IRWre`=0, `fetch_done`=0, `fault`=0, `busy`=0.
- Zero-wait memory (`mem_ready`=1 throughout RD):
  - Accept edge E0.
  - Bytes captured at E1 through E4.
  - `IRWre` high from E4 to E5; IDLE at E5.
  - Next accept possible at E6.
- Each wait cycle with `mem_ready`=0 extends RD by one cycle.
- `Ins_Data` is stable for the whole `IRWre` cycle, so it is stable at the intervening falling edge.
- Misaligned PC: `fault` high from E0 to E1.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A per-byte wait counter counts RD cycles with `mem_ready`=0.
  - The counter clears on each captured byte.
  - When the count reaches `TIMEOUT_CYCLES`, drop `mem_rd`, pulse `fault` for one cycle, return to IDLE, and leave `Ins_Data` unchanged.
- `FETCH_TIMEOUT_EN` not defined: no counter, and RD waits indefinitely for `mem_ready`.

## Structure
- Shared package `cpu_fetch_pkg`:
  - state enum (IDLE, RD, DONE);
  - `BYTES_PER_INS`=4;
  - default `TIMEOUT_CYCLES` constant.
- One sub-module, `ins_byte_packer`: 32-bit shift-in shadow register with `shift_en`, `clr` and an 8-bit input. The FSM and timeout counter remain in `ins_fetch_unit`.

## Test plan
- **Zero-wait fetch**: `PC_in`=0x00000010, memory bytes 0x8C,0x22,0x00,0x04 → `mem_addr` steps 0x10 to 0x13; `Ins_Data`=0x8C220004; `IRWre` high exactly one cycle, 5 cycles after accept.
- **Wait states**: same fetch with `mem_ready` low for 2 cycles before byte 2 → `IRWre` 7 cycles after accept, same data.
- **Misaligned PC**: `PC_in`=0x00000012 → one-cycle `fault`, `mem_rd` never asserted, `Ins_Data` keeps its previous value.
- **Reset mid-fetch**: `Reset` low after byte 1 → all outputs 0 immediately, no `IRWre`; a new fetch after release completes normally.
- **Busy/back-to-back**: `fetch_req` held high → a second fetch starts at E6, and requests during RD/DONE create no extra fetch.
- **Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16)**: `mem_ready` stuck low → `fault` after 16 wait cycles, then IDLE, `Ins_Data` unchanged.
